// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: fetches an RGB444 frame, paces pixels into the grey/edge pipeline, flushes, stores results.
// Read-to-strobe latency 2 cycles, strobes every PACE cycles; results are written one cycle after res_valid.
module conv_frame_sequencer #(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int PACE      = 2,
   parameter int FLUSH_PIX = 2,
   parameter int TIMEOUT   = 4096,
   localparam int NPIX     = IMG_W * IMG_H,
   localparam int AW       = $clog2(NPIX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err_timeout,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [11:0]   rd_data,
   output logic [11:0]   pix_out,
   output logic          pix_valid,
   input  logic [3:0]    res_in,
   input  logic          res_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [3:0]    wr_data,
   output logic [AW:0]   out_count
);

   localparam int PW = $clog2(PACE + 1);
   localparam int FW = $clog2(FLUSH_PIX + 2);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int WAIT_LAST  = (PACE > 2) ? PACE - 3 : 0;
   localparam int FLUSH_LAST = (FLUSH_PIX > 0) ? FLUSH_PIX - 1 : 0;

   localparam logic [AW:0]   NPIX_V   = (AW+1)'(NPIX);
   localparam logic [AW:0]   LAST_IDX = (AW+1)'(NPIX - 1);
   localparam logic [PW-1:0] PACE_END = PW'(PACE - 1);
   localparam logic [PW-1:0] WAIT_END = PW'(WAIT_LAST);
   localparam logic [FW-1:0] FLSH_END = FW'(FLUSH_LAST);
   localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_FLUSH, S_DRAIN
   } state_t;

   state_t        state;
   logic [AW:0]   in_idx;
   logic [PW-1:0] pace_cnt;
   logic [FW-1:0] flush_cnt;
   logic [TW-1:0] tmo_cnt;

   // The frame-buffer read is issued combinationally so rd_data lands exactly in ISSUE.
   assign rd_en   = (state == S_FETCH);
   assign rd_addr = in_idx[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         pix_out     <= '0;
         pix_valid   <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         out_count   <= '0;
         in_idx      <= '0;
         pace_cnt    <= '0;
         flush_cnt   <= '0;
         tmo_cnt     <= '0;
      end else begin
         pix_valid <= 1'b0;
         done      <= 1'b0;
         wr_en     <= 1'b0;

         if (busy && res_valid && (out_count < NPIX_V)) begin
            wr_en     <= 1'b1;
            wr_data   <= res_in;
            wr_addr   <= out_count[AW-1:0];
            out_count <= out_count + 1'b1;
         end

         case (state)
            S_IDLE: begin
               // A start coinciding with the done pulse belongs to the frame just closed.
               if (start && !done) begin
                  state       <= S_FETCH;
                  busy        <= 1'b1;
                  in_idx      <= '0;
                  out_count   <= '0;
                  err_timeout <= 1'b0;
               end
            end

            S_FETCH: state <= S_ISSUE;

            S_ISSUE: begin
               pix_out   <= rd_data;
               pix_valid <= 1'b1;
               in_idx    <= in_idx + 1'b1;
               pace_cnt  <= '0;
               flush_cnt <= '0;
               if (in_idx == LAST_IDX) begin
                  if (FLUSH_PIX == 0) begin
                     state   <= S_DRAIN;
                     tmo_cnt <= '0;
                  end else begin
                     state <= S_FLUSH;
                  end
               end else if (PACE > 2) begin
                  state <= S_WAIT;
               end else begin
                  state <= S_FETCH;
               end
            end

            S_WAIT: begin
               if (pace_cnt == WAIT_END) begin
                  state    <= S_FETCH;
                  pace_cnt <= '0;
               end else begin
                  pace_cnt <= pace_cnt + 1'b1;
               end
            end

            S_FLUSH: begin
               // Flush strobes land on the same PACE grid as frame pixels.
               if (pace_cnt == PACE_END) begin
                  pix_out   <= '0;
                  pix_valid <= 1'b1;
                  pace_cnt  <= '0;
                  if (flush_cnt == FLSH_END) begin
                     state   <= S_DRAIN;
                     tmo_cnt <= '0;
                  end else begin
                     flush_cnt <= flush_cnt + 1'b1;
                  end
               end else begin
                  pace_cnt <= pace_cnt + 1'b1;
               end
            end

            S_DRAIN: begin
               if (out_count == NPIX_V) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (!res_valid && (tmo_cnt == TMO_END)) begin
                  state       <= S_IDLE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  err_timeout <= 1'b1;
               end else if (res_valid) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt != TMO_MAX) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer: two instances (PACE=2 and PACE=5) on a 4x3 frame.
module tb_conv_frame_sequencer;

   localparam int NPIX = 12;
   localparam int AW   = 4;
   localparam int TMO  = 64;
   localparam int LOGN = 512;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]          start, busy, done, err, rd_en, pix_valid, res_valid, wr_en;
   logic [1:0][AW-1:0]  rd_addr, wr_addr;
   logic [1:0][11:0]    rd_data, pix_out;
   logic [1:0][3:0]     res_in, wr_data;
   logic [1:0][AW:0]    out_count;

   conv_frame_sequencer #(.IMG_W(4), .IMG_H(3), .PACE(2), .FLUSH_PIX(2), .TIMEOUT(TMO)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .err_timeout(err[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
      .pix_out(pix_out[0]), .pix_valid(pix_valid[0]), .res_in(res_in[0]),
      .res_valid(res_valid[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
      .wr_data(wr_data[0]), .out_count(out_count[0]));

   conv_frame_sequencer #(.IMG_W(4), .IMG_H(3), .PACE(5), .FLUSH_PIX(2), .TIMEOUT(TMO)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .err_timeout(err[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
      .pix_out(pix_out[1]), .pix_valid(pix_valid[1]), .res_in(res_in[1]),
      .res_valid(res_valid[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
      .wr_data(wr_data[1]), .out_count(out_count[1]));

   // Environment: frame buffer, loopback pipeline of programmable depth
   logic [11:0]       mem [2][16];
   int                pace_of [2] = '{2, 5};
   int                lb_dly [2]  = '{3, 3};
   logic [1:0]        lb_en;
   logic [1:0][7:0]   pv_sh;
   logic [1:0][7:0][3:0] px_sh;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         pv_sh[k] <= {pv_sh[k][6:0], pix_valid[k]};
         px_sh[k] <= {px_sh[k][6:0], pix_out[k][3:0]};
         if (rd_en[k]) rd_data[k] <= mem[k][rd_addr[k]];
      end
   end

   always_comb begin
      res_valid = '0;
      res_in    = '0;
      for (int k = 0; k < 2; k++) begin
         res_valid[k] = lb_en[k] & pv_sh[k][lb_dly[k]-1];
         res_in[k]    = px_sh[k][lb_dly[k]-1];
      end
   end

   // Event logs
   int          cyc = 0;
   int          pv_n [2] = '{0, 0};
   int          wr_n [2] = '{0, 0};
   int          rd_n [2] = '{0, 0};
   int          done_n [2] = '{0, 0};
   int          done_cyc [2];
   int          pv_cyc [2][LOGN];
   logic [11:0] pv_dat [2][LOGN];
   logic [3:0]  wr_a [2][LOGN];
   logic [3:0]  wr_d [2][LOGN];
   logic [3:0]  rd_a [2][LOGN];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (pix_valid[k] === 1'b1 && pv_n[k] < LOGN) begin
            pv_cyc[k][pv_n[k]] = cyc;
            pv_dat[k][pv_n[k]] = pix_out[k];
            pv_n[k]++;
         end
         if (wr_en[k] === 1'b1 && wr_n[k] < LOGN) begin
            wr_a[k][wr_n[k]] = wr_addr[k];
            wr_d[k][wr_n[k]] = wr_data[k];
            wr_n[k]++;
         end
         if (rd_en[k] === 1'b1 && rd_n[k] < LOGN) begin
            rd_a[k][rd_n[k]] = rd_addr[k];
            rd_n[k]++;
         end
         if (done[k] === 1'b1) begin
            done_cyc[k] = cyc;
            done_n[k]++;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_frame(input int k, input int dly, input bit en, input int restart_at,
                            output int bpv, output int bwr, output int brd, output int bdone);
      int  n;
      bit  sent;
      lb_dly[k] = dly;
      lb_en[k]  = en;
      bpv = pv_n[k]; bwr = wr_n[k]; brd = rd_n[k]; bdone = done_n[k];
      n = 0; sent = 0;
      start[k] = 1'b1;
      step();
      start[k] = 1'b0;
      while (done[k] !== 1'b1 && n < 3000) begin
         step();
         n++;
         if (restart_at > 0 && !sent && (pv_n[k] - bpv) == restart_at) begin
            start[k] = 1'b1;
            sent = 1;
         end else begin
            start[k] = 1'b0;
         end
      end
      start[k] = 1'b0;
      chk($sformatf("d%0d_done_seen", k), done[k], 1'b1);
      repeat (12) step();
   endtask

   // Expected behaviour derived from the frame contents: every pixel then two zeros,
   // PACE apart, one read per pixel in address order, and (with loopback) one write per
   // frame pixel carrying its low nibble.
   task automatic check_frame(input int k, input int bpv, input int bwr, input int brd,
                              input int bdone, input bit results);
      int np;
      np = pv_n[k] - bpv;
      chk($sformatf("d%0d_pulse_count", k), np, NPIX + 2);
      for (int i = 0; i < NPIX + 2 && i < np; i++) begin
         logic [11:0] e;
         e = (i < NPIX) ? mem[k][i] : 12'h000;
         chk($sformatf("d%0d_pix%0d", k, i), pv_dat[k][bpv+i], e);
         if (i > 0)
            chk($sformatf("d%0d_gap%0d", k, i), pv_cyc[k][bpv+i] - pv_cyc[k][bpv+i-1], pace_of[k]);
      end
      chk($sformatf("d%0d_rd_count", k), rd_n[k] - brd, NPIX);
      for (int i = 0; i < NPIX && i < rd_n[k] - brd; i++)
         chk($sformatf("d%0d_rd_addr%0d", k, i), rd_a[k][brd+i], i);
      if (results) begin
         chk($sformatf("d%0d_wr_count", k), wr_n[k] - bwr, NPIX);
         for (int i = 0; i < NPIX && i < wr_n[k] - bwr; i++) begin
            chk($sformatf("d%0d_wr_addr%0d", k, i), wr_a[k][bwr+i], i);
            chk($sformatf("d%0d_wr_data%0d", k, i), wr_d[k][bwr+i], mem[k][i][3:0]);
         end
         chk($sformatf("d%0d_out_count", k), out_count[k], NPIX);
         chk($sformatf("d%0d_err_clear", k), err[k], 1'b0);
      end else begin
         chk($sformatf("d%0d_wr_none", k), wr_n[k] - bwr, 0);
         chk($sformatf("d%0d_out_count0", k), out_count[k], 0);
         chk($sformatf("d%0d_err_set", k), err[k], 1'b1);
      end
      chk($sformatf("d%0d_done_once", k), done_n[k] - bdone, 1);
      chk($sformatf("d%0d_idle", k), busy[k], 1'b0);
   endtask

   task automatic check_quiet(input string tag, input int k);
      chk({tag, "_busy"}, busy[k], 1'b0);
      chk({tag, "_done"}, done[k], 1'b0);
      chk({tag, "_err"}, err[k], 1'b0);
      chk({tag, "_rd_en"}, rd_en[k], 1'b0);
      chk({tag, "_pix_valid"}, pix_valid[k], 1'b0);
      chk({tag, "_pix_out"}, pix_out[k], 12'h000);
      chk({tag, "_wr_en"}, wr_en[k], 1'b0);
      chk({tag, "_wr_bus"}, {wr_addr[k], wr_data[k], rd_addr[k]}, 0);
      chk({tag, "_out_count"}, out_count[k], 0);
   endtask

   initial begin
      int bpv, bwr, brd, bdone, n, last;
      rst = 1'b1;
      start = '0;
      lb_en = '0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) mem[k][i] = 12'h100 + 12'(i);
      repeat (3) step();
      check_quiet("rst0", 0);
      check_quiet("rst1", 1);
      rst = 1'b0;
      repeat (2) step();

      // Counting pattern with a 3-cycle loopback
      run_frame(0, 3, 1'b1, 0, bpv, bwr, brd, bdone);
      check_frame(0, bpv, bwr, brd, bdone, 1'b1);

      // Slow pacing, random frame and pipeline depth
      for (int i = 0; i < NPIX; i++) mem[1][i] = 12'($urandom);
      run_frame(1, int'($urandom_range(1, 6)), 1'b1, 0, bpv, bwr, brd, bdone);
      check_frame(1, bpv, bwr, brd, bdone, 1'b1);

      // No results at all: timeout exactly TMO cycles after the last flush strobe
      for (int i = 0; i < NPIX; i++) mem[0][i] = 12'($urandom);
      run_frame(0, 3, 1'b0, 0, bpv, bwr, brd, bdone);
      check_frame(0, bpv, bwr, brd, bdone, 1'b0);
      last = pv_n[0] - 1;
      chk("timeout_latency", done_cyc[0] - pv_cyc[0][last], TMO);

      // Second start during the third strobe is ignored; also clears the sticky error
      for (int i = 0; i < NPIX; i++) mem[0][i] = 12'($urandom);
      run_frame(0, int'($urandom_range(1, 6)), 1'b1, 3, bpv, bwr, brd, bdone);
      check_frame(0, bpv, bwr, brd, bdone, 1'b1);

      // Asynchronous reset after the fifth strobe, then a clean restart from address 0
      for (int i = 0; i < NPIX; i++) mem[0][i] = 12'($urandom);
      lb_dly[0] = 3;
      lb_en[0]  = 1'b1;
      bpv = pv_n[0];
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      n = 0;
      while ((pv_n[0] - bpv) < 5 && n < 500) begin
         step();
         n++;
      end
      chk("rst_mid_reached5", pv_n[0] - bpv, 5);
      chk("rst_mid_pulse_high", pix_valid[0], 1'b1);
      rst = 1'b1;
      #1;
      check_quiet("rst_mid", 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (10) step();
      run_frame(0, int'($urandom_range(1, 6)), 1'b1, 0, bpv, bwr, brd, bdone);
      check_frame(0, bpv, bwr, brd, bdone, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
